// File: rtl/dvid_pkg.sv
// TMDS receive definitions: control tokens, token-to-c mapping, 10->8 decode, alignment states.
// Constants and pure functions only.
package dvid_pkg;

    localparam logic [9:0] TOK_C00    = 10'h354;
    localparam logic [9:0] TOK_C01    = 10'h0AB;
    localparam logic [9:0] TOK_C10    = 10'h154;
    localparam logic [9:0] TOK_C11    = 10'h2AB;
    localparam logic [3:0] OFFSET_MAX = 4'd9;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } align_state_e;

    function automatic logic is_ctrl_token(input logic [9:0] q);
        return (q == TOK_C00) || (q == TOK_C01) || (q == TOK_C10) || (q == TOK_C11);
    endfunction

    function automatic logic [1:0] token_to_c(input logic [9:0] q);
        logic [1:0] c;
        case (q)
            TOK_C01: c = 2'b01;
            TOK_C10: c = 2'b10;
            TOK_C11: c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    // Undo the transition-minimising encode: optional inversion, then XOR/XNOR chain.
    function automatic logic [7:0] tmds_decode(input logic [9:0] q);
        logic [7:0] d;
        logic [7:0] o;
        d    = q[9] ? ~q[7:0] : q[7:0];
        o    = '0;
        o[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            o[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return o;
    endfunction

    function automatic logic [3:0] next_offset(input logic [3:0] off);
        return (off >= OFFSET_MAX) ? 4'd0 : off + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_channel_decoder.sv
// One TMDS lane: register raw word, rotate by the searched offset, decode; 2-cycle latency.
// Free-running, no backpressure; alignment FSM steps the rotation until control tokens line up.
module tmds_channel_decoder
    import dvid_pkg::*;
#(
    parameter int C_depth       = 8,
    parameter int C_lock_tokens = 16,
    parameter int C_window      = 2048
) (
    input  logic               clk_pixel,
    input  logic               resetn,
    input  logic [9:0]         word_i,
    output logic [C_depth-1:0] data_o,
    output logic               is_token_o,
    output logic [1:0]         c_o,
    output logic               locked_o,
    output logic [3:0]         offset_o
);

    localparam int RUN_W = $clog2(C_lock_tokens + 1);
    localparam int WIN_W = $clog2(C_window);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(C_lock_tokens);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(C_window - 1);

    logic [9:0]         raw_q;
    logic [19:0]        raw_dbl;
    logic [9:0]         aligned;
    logic               token;
    logic [7:0]         decoded;
    logic [C_depth-1:0] data_d, data_q;
    logic               tok_q;
    logic [1:0]         c_d, c_q;
    align_state_e       state_d, state_q;
    logic [RUN_W-1:0]   run_d, run_q, run_inc;
    logic [WIN_W-1:0]   win_d, win_q;
    logic [3:0]         off_d, off_q;
    logic               hit;
    logic               expire;

    // aligned = bits [off+9:off] of {raw, raw}
    assign raw_dbl = {raw_q, raw_q};
    assign aligned = 10'(raw_dbl >> off_q);
    assign token   = is_ctrl_token(aligned);
    assign decoded = tmds_decode(aligned);

    assign data_d = token ? '0 : C_depth'(decoded >> (8 - C_depth));
    // Last control code is held so sync outputs survive the data period.
    assign c_d    = token ? token_to_c(aligned) : c_q;

    assign run_inc = (run_q == RUN_LOCK) ? run_q : run_q + RUN_W'(1);
    assign hit     = token && (run_q >= RUN_LOCK - RUN_W'(1));
    assign expire  = (win_q == WIN_LAST);

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        win_d   = win_q + WIN_W'(1);
        run_d   = token ? run_inc : '0;
        case (state_q)
            ST_SEARCH: begin
                if (hit) begin
                    state_d = ST_LOCKED;
                    win_d   = '0;
                end else if (expire) begin
                    off_d = next_offset(off_q);
                    run_d = '0;
                    win_d = '0;
                end
            end
            ST_LOCKED: begin
                if (hit) begin
                    win_d = '0;
                end else if (expire) begin
                    state_d = ST_SEARCH;
                    off_d   = next_offset(off_q);
                    run_d   = '0;
                    win_d   = '0;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            raw_q   <= '0;
            data_q  <= '0;
            tok_q   <= 1'b1;
            c_q     <= '0;
            state_q <= ST_SEARCH;
            run_q   <= '0;
            win_q   <= '0;
            off_q   <= '0;
        end else begin
            raw_q   <= word_i;
            data_q  <= data_d;
            tok_q   <= token;
            c_q     <= c_d;
            state_q <= state_d;
            run_q   <= run_d;
            win_q   <= win_d;
            off_q   <= off_d;
        end
    end

    assign data_o     = data_q;
    assign is_token_o = tok_q;
    assign c_o        = c_q;
    assign locked_o   = (state_q == ST_LOCKED);
    assign offset_o   = off_q;

endmodule

// File: rtl/dvid2vga.sv
// TMDS-to-VGA receive: three aligned lane decoders, blue-lane sync/blank, combined lock flag.
// Free-running at 2 clk_pixel latency, no backpressure; lock indication trails by one cycle.
module dvid2vga
    import dvid_pkg::*;
#(
    parameter int C_depth       = 8,
    parameter int C_lock_tokens = 16,
    parameter int C_window      = 2048
) (
    input  logic               clk_pixel,
    input  logic               resetn,
    input  logic [9:0]         in_red,
    input  logic [9:0]         in_green,
    input  logic [9:0]         in_blue,
    output logic [C_depth-1:0] out_red,
    output logic [C_depth-1:0] out_green,
    output logic [C_depth-1:0] out_blue,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_blank,
    output logic               out_locked,
    output logic [11:0]        out_offset
);

    logic       r_tok, g_tok, b_tok;
    logic [1:0] r_c, g_c, b_c;
    logic       r_lk, g_lk, b_lk;
    logic [3:0] r_off, g_off, b_off;
    logic       locked_d, locked_q;
    logic       unused_ctrl;

    tmds_channel_decoder #(
        .C_depth(C_depth), .C_lock_tokens(C_lock_tokens), .C_window(C_window)
    ) u_red (
        .clk_pixel (clk_pixel),
        .resetn    (resetn),
        .word_i    (in_red),
        .data_o    (out_red),
        .is_token_o(r_tok),
        .c_o       (r_c),
        .locked_o  (r_lk),
        .offset_o  (r_off)
    );

    tmds_channel_decoder #(
        .C_depth(C_depth), .C_lock_tokens(C_lock_tokens), .C_window(C_window)
    ) u_green (
        .clk_pixel (clk_pixel),
        .resetn    (resetn),
        .word_i    (in_green),
        .data_o    (out_green),
        .is_token_o(g_tok),
        .c_o       (g_c),
        .locked_o  (g_lk),
        .offset_o  (g_off)
    );

    tmds_channel_decoder #(
        .C_depth(C_depth), .C_lock_tokens(C_lock_tokens), .C_window(C_window)
    ) u_blue (
        .clk_pixel (clk_pixel),
        .resetn    (resetn),
        .word_i    (in_blue),
        .data_o    (out_blue),
        .is_token_o(b_tok),
        .c_o       (b_c),
        .locked_o  (b_lk),
        .offset_o  (b_off)
    );

    // Only the blue lane carries hsync/vsync; red/green control codes are ignored.
    assign unused_ctrl = ^{r_tok, g_tok, r_c, g_c};

    assign out_hsync  = b_c[0];
    assign out_vsync  = b_c[1];
    assign out_blank  = b_tok;
    assign out_offset = {r_off, g_off, b_off};

    assign locked_d = r_lk & g_lk & b_lk;

    always_ff @(posedge clk_pixel or negedge resetn) begin
        if (!resetn) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_d;
        end
    end

    assign out_locked = locked_q;

endmodule

// File: tb/tb_dvid2vga.sv
// Directed bench for dvid2vga: scoreboard on the pixel pipeline plus lock/offset sequencing.
module tb_dvid2vga;

    logic        clk_pixel = 1'b0;
    logic        resetn    = 1'b1;
    logic [9:0]  in_red, in_green, in_blue;
    logic [7:0]  out_red, out_green, out_blue;
    logic        out_hsync, out_vsync, out_blank, out_locked;
    logic [11:0] out_offset;
    logic [2:0]  d3_red, d3_green, d3_blue;
    logic        d3_hsync, d3_vsync, d3_blank, d3_locked;
    logic [11:0] d3_offset;

    always #5 clk_pixel = ~clk_pixel;

    dvid2vga #(.C_depth(8), .C_lock_tokens(16), .C_window(2048)) dut (
        .clk_pixel(clk_pixel), .resetn(resetn),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_blank(out_blank),
        .out_locked(out_locked), .out_offset(out_offset)
    );

    dvid2vga #(.C_depth(3), .C_lock_tokens(16), .C_window(2048)) dut3 (
        .clk_pixel(clk_pixel), .resetn(resetn),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_red(d3_red), .out_green(d3_green), .out_blue(d3_blue),
        .out_hsync(d3_hsync), .out_vsync(d3_vsync), .out_blank(d3_blank),
        .out_locked(d3_locked), .out_offset(d3_offset)
    );

    typedef struct {
        int         due;
        logic [7:0] r, g, b;
        logic       blank, hs, vs, lock;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   lp     = 0;

    always @(posedge clk_pixel) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
        logic [19:0] d;
        d = {w, w};
        return d[19-n -: 10];
    endfunction

    function automatic logic [3:0] next_off(input logic [3:0] x);
        return (x == 4'd9) ? 4'd0 : x + 4'd1;
    endfunction

    // Output for a word driven after edge k is registered at edge k+2.
    always @(negedge clk_pixel) begin
        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            mon_e = sbq.pop_front();
            chk("sb_red",      out_red,   mon_e.r);
            chk("sb_green",    out_green, mon_e.g);
            chk("sb_blue",     out_blue,  mon_e.b);
            chk("sb_blank",    out_blank, mon_e.blank);
            chk("sb_hsync",    out_hsync, mon_e.hs);
            chk("sb_vsync",    out_vsync, mon_e.vs);
            chk("sb_locked",   out_locked, mon_e.lock);
            chk("sb_d3_red",   d3_red,   mon_e.r[7:5]);
            chk("sb_d3_green", d3_green, mon_e.g[7:5]);
            chk("sb_d3_blue",  d3_blue,  mon_e.b[7:5]);
            chk("sb_d3_blank", d3_blank, mon_e.blank);
            chk("sb_d3_sync",  {d3_vsync, d3_hsync}, {mon_e.vs, mon_e.hs});
        end
    end

    task automatic put(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                       input logic do_chk, input logic [7:0] er, input logic [7:0] eg,
                       input logic [7:0] eb, input logic ebl, input logic ehs,
                       input logic evs, input logic elk);
        exp_t e;
        @(posedge clk_pixel);
        #1;
        in_red   = r;
        in_green = g;
        in_blue  = b;
        if (do_chk) begin
            e.due   = cyc + 2;
            e.r     = er;
            e.g     = eg;
            e.b     = eb;
            e.blank = ebl;
            e.hs    = ehs;
            e.vs    = evs;
            e.lock  = elk;
            sbq.push_back(e);
        end
    endtask

    task automatic vec(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                       input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                       input logic ebl, input logic ehs, input logic evs);
        put(r, g, b, 1'b1, er, eg, eb, ebl, ehs, evs, 1'b1);
    endtask

    // 800-cycle line, first 160 words are 10'h354 blanking when tokens are enabled.
    task automatic line_word(input int rot_rg, input int rot_b, input bit tok_on, input bit do_chk);
        logic [9:0] w;
        logic [7:0] ev;
        logic       is_tok;
        is_tok = tok_on && (lp < 160);
        if (is_tok) begin
            w  = 10'h354;
            ev = 8'h00;
        end else if (lp % 2 == 1) begin
            w  = 10'h2FF;
            ev = 8'hFE;
        end else begin
            w  = 10'h100;
            ev = 8'h00;
        end
        put(rotl(w, rot_rg), rotl(w, rot_rg), rotl(w, rot_b), do_chk,
            ev, ev, ev, is_tok, 1'b0, 1'b0, 1'b1);
        lp = (lp == 799) ? 0 : lp + 1;
    endtask

    initial begin
        logic [3:0] last_b;
        int         steps;
        in_red   = '0;
        in_green = '0;
        in_blue  = '0;
        #1 resetn = 1'b0;
        #2;
        chk("rst_red",    out_red,    8'h00);
        chk("rst_green",  out_green,  8'h00);
        chk("rst_blue",   out_blue,   8'h00);
        chk("rst_sync",   {out_vsync, out_hsync}, 2'b00);
        chk("rst_blank",  out_blank,  1'b1);
        chk("rst_locked", out_locked, 1'b0);
        chk("rst_offset", out_offset, 12'h000);
        repeat (3) @(negedge clk_pixel);
        resetn = 1'b1;

        // Search with no tokens, then async reset once the offsets reach 5.
        for (int i = 0; i < 6 * 2048 && out_offset[11:8] != 4'd5; i++) @(negedge clk_pixel);
        chk("srch_offset5", out_offset, 12'h555);
        #2 resetn = 1'b0;
        #1;
        chk("arst_offset", out_offset, 12'h000);
        chk("arst_blank",  out_blank,  1'b1);
        chk("arst_locked", out_locked, 1'b0);
        repeat (2) @(negedge clk_pixel);
        resetn = 1'b1;
        repeat (3) @(negedge clk_pixel);

        // Aligned tokens: lock visible on the 17th word's output (cycle 18).
        for (int n = 0; n < 20; n++) begin
            put(10'h354, 10'h354, 10'h354, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, n >= 16);
        end

        // Decode and sync-hold vectors.
        vec(10'h100, 10'h2FF, 10'h10F, 8'h00, 8'hFE, 8'h11, 1'b0, 1'b0, 1'b0);
        vec(10'h0FF, 10'h300, 10'h2FF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
        vec(10'h354, 10'h354, 10'h2AB, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        vec(10'h2FF, 10'h100, 10'h0FF, 8'hFE, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
        vec(10'h10F, 10'h0FF, 10'h300, 8'h11, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
        vec(10'h354, 10'h354, 10'h0AB, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        vec(10'h300, 10'h10F, 10'h100, 8'h01, 8'h11, 8'h00, 1'b0, 1'b1, 1'b0);
        vec(10'h354, 10'h354, 10'h154, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        vec(10'h100, 10'h100, 10'h2FF, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b1);
        vec(10'h354, 10'h354, 10'h354, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        vec(10'h2FF, 10'h2FF, 10'h2FF, 8'hFE, 8'hFE, 8'hFE, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk_pixel);
        chk("aligned_offset", out_offset, 12'h000);
        chk("aligned_locked", out_locked, 1'b1);
        chk("d3_locked",      d3_locked,  1'b1);
        chk("d3_offset",      d3_offset,  12'h000);

        // Blue lane rotated by 3: offset must walk 0,1,2,3 and then lock.
        resetn = 1'b0;
        @(negedge clk_pixel);
        resetn = 1'b1;
        lp     = 0;
        last_b = 4'd0;
        steps  = 0;
        for (int t = 0; t < 4 * 2048 + 800 && out_locked !== 1'b1; t++) begin
            line_word(0, 3, 1'b1, 1'b0);
            if (out_offset[3:0] != last_b) begin
                chk("rot_step", out_offset[3:0], next_off(last_b));
                last_b = out_offset[3:0];
                steps++;
            end
        end
        chk("rot_locked", out_locked, 1'b1);
        chk("rot_steps",  steps, 3);
        chk("rot_offset", out_offset, 12'h003);
        for (int t = 0; t < 200; t++) line_word(0, 3, 1'b1, 1'b1);

        // Token starvation drops lock and advances every offset once.
        for (int t = 0; t < 2100; t++) line_word(0, 3, 1'b0, 1'b0);
        chk("loss_locked", out_locked, 1'b0);
        chk("loss_offset", out_offset, 12'h114);
        for (int t = 0; t < 10 * 2048 + 1600 && out_locked !== 1'b1; t++) line_word(0, 3, 1'b1, 1'b0);
        chk("relock_locked", out_locked, 1'b1);
        chk("relock_offset", out_offset, 12'h003);

        repeat (4) @(negedge clk_pixel);
        chk("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
